// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU for HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// start is taken only when idle; HI/LO and a done pulse follow N+1 edges later, busy is high in between.
module mul_div_unit #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] nA,
  input  logic [N-1:0] nB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic           is_div;
  logic           neg_res;
  logic           neg_rem;
  logic           dbz;
  logic [N-1:0]   opd;
  logic [N-1:0]   rem;
  logic [2*N-1:0] acc;

  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic [N-1:0]   div_diff;
  logic           div_ge;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix, rem_fix;

  // Multiply: acc = {partial product, remaining multiplier bits}, opd = multiplicand.
  // Divide:   acc[N-1:0] shifts dividend bits out and quotient bits in, opd = divisor.
  always_comb begin
    a_neg     = op[0] & nA[N-1];
    b_neg     = op[0] & nB[N-1];
    a_mag     = a_neg ? -nA : nA;
    b_mag     = b_neg ? -nB : nB;
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opd} : {(N+1){1'b0}});
    div_shift = {rem, acc[N-1]};
    div_ge    = div_shift >= {1'b0, opd};
    // The difference is below the divisor whenever it is kept, so N bits suffice.
    div_diff  = div_shift[N-1:0] - opd;
    prod_fix  = neg_res ? -acc : acc;
    quo_fix   = dbz ? {N{1'b1}} : (neg_res ? -acc[N-1:0] : acc[N-1:0]);
    rem_fix   = neg_rem ? -rem : rem;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(N-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dbz         <= 1'b0;
      opd         <= '0;
      rem         <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= op[1] & a_neg;
            dbz     <= op[1] & (nB == '0);
            rem     <= '0;
            if (op[1]) begin
              opd <= b_mag;
              acc <= {{N{1'b0}}, a_mag};
            end else begin
              opd <= a_mag;
              acc <= {{N{1'b0}}, b_mag};
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem         <= div_ge ? div_diff : div_shift[N-1:0];
            acc[N-1:0]  <= {acc[N-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[N-1:1]};
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end
          done        <= 1'b1;
          div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector scoreboard bench for mul_div_unit: expectations queued at issue, checked on done.
module tb_mul_div_unit;

  localparam int N   = 32;
  localparam int LAT = N + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [N-1:0]  nA, nB;
  logic          busy, done, div_by_zero;
  logic [N-1:0]  hi, lo;

  mul_div_unit #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .nA          (nA),
    .nB          (nB),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   edge_cnt = 0;
  int   bcnt = 0;
  bit   moved = 0;
  logic [N-1:0] prev_hi = '0, prev_lo = '0;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    int   want_edge;
    if (!rst_n) begin
      bcnt  = 0;
      moved = 0;
    end else begin
      if (busy && (hi !== prev_hi || lo !== prev_lo)) moved = 1;
      if (busy) bcnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: done with no op pending (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("hi", 64'(hi), 64'(e.hi));
          chk("lo", 64'(lo), 64'(e.lo));
          chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
          chk("busy_in_done_cycle", 64'(busy), 64'd0);
          chk("busy_cycles", 64'(bcnt), 64'(LAT));
          chk("hilo_held_while_busy", 64'(moved), 64'd0);
          if (done_q.size() > 0) begin
            want_edge = done_q.pop_front();
            chk("latency_edge", 64'(edge_cnt), 64'(want_edge));
          end else begin
            n_vec++;
            n_miss++;
            $display("FAIL latency_edge: no accept edge recorded (t=%0t)", $time);
          end
        end
        bcnt  = 0;
        moved = 0;
      end
    end
    prev_hi = hi;
    prev_lo = lo;
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                       input bit track);
    exp_t e;
    start = 1'b1;
    op    = o;
    nA    = a;
    nB    = b;
    e     = {ehi, elo, edbz};
    if (track) exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (track) done_q.push_back(edge_cnt + LAT);
    start = 1'b0;
    op    = 2'($urandom);
    nA    = $urandom;
    nB    = $urandom;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL done_timeout: done not seen within %0d cycles (t=%0t)", 4 * LAT, $time);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    issue(o, a, b, ehi, elo, edbz, 1'b1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    nA    = '0;
    nB    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
    run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run(2'b01, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run(2'b01, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
    run(2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run(2'b11, 32'h00000003, 32'hFFFFFFF9, 32'h00000003, 32'h00000000, 1'b0);
    run(2'b11, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFD, 32'h00000000, 1'b0);
    run(2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1);
    run(2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    run(2'b00, 32'hFFFF0000, 32'h00010000, 32'h0000FFFF, 32'h00000000, 1'b0);

    // A start held during cycles 5..20 of a busy op must be dropped entirely.
    issue(2'b10, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 2'b00;
    nA    = 32'd5;
    nB    = 32'd5;
    repeat (16) @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    // Requested in the done cycle: accepted at the very next edge.
    run(2'b01, 32'h00010001, 32'h00010000, 32'h00000001, 32'h00010000, 1'b0);
    run(2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

    // Reset mid-operation: outputs clear immediately, the aborted op never completes.
    issue(2'b00, 32'h12345678, 32'h00000010, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_hi", 64'(hi), 64'd0);
    chk("arst_lo", 64'(lo), 64'd0);
    chk("arst_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_held_idle", 64'(busy), 64'd0);
    rst_n = 1'b1;
    run(2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    repeat (3) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
